// File: rtl/evm_pkg.sv
// Shared types and constants for the EVM vote sequencing logic.
package evm_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        DEBOUNCE     = 2'd1,
        WAIT_RELEASE = 2'd2,
        LOCKOUT      = 2'd3
    } state_t;

    localparam int NUM_CAND = 4;
    localparam int CAND_W   = 2;
    localparam int VOTE_W   = 8;
    localparam int TOTAL_W  = 10;
    localparam logic [VOTE_W-1:0] VOTE_MAX = 8'd255;

    // Index of the lowest set bit; callers only pass one-hot vectors.
    function automatic logic [CAND_W-1:0] onehot_to_idx(input logic [NUM_CAND-1:0] oh);
        logic [CAND_W-1:0] idx;
        idx = '0;
        for (int i = NUM_CAND - 1; i >= 0; i--) begin
            if (oh[i]) idx = CAND_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [NUM_CAND-1:0] idx_to_mask(input logic [CAND_W-1:0] idx);
        return NUM_CAND'(1) << idx;
    endfunction

endpackage

// File: rtl/vote_cast_controller_if.sv
// Button, mode and tally signals between the vote controller and its environment.
interface vote_cast_controller_if;
    import evm_pkg::*;

    logic                mode;
    logic                clear_votes;
    logic                cand1_button_press;
    logic                cand2_button_press;
    logic                cand3_button_press;
    logic                cand4_button_press;
    logic [VOTE_W-1:0]   cand1_vote;
    logic [VOTE_W-1:0]   cand2_vote;
    logic [VOTE_W-1:0]   cand3_vote;
    logic [VOTE_W-1:0]   cand4_vote;
    logic [TOTAL_W-1:0]  total_votes;
    logic                valid_vote_casted;
    logic                vote_rejected;
    logic                busy;

    modport master (
        output mode, clear_votes,
        output cand1_button_press, cand2_button_press, cand3_button_press, cand4_button_press,
        input  cand1_vote, cand2_vote, cand3_vote, cand4_vote,
        input  total_votes, valid_vote_casted, vote_rejected, busy
    );

    modport slave (
        input  mode, clear_votes,
        input  cand1_button_press, cand2_button_press, cand3_button_press, cand4_button_press,
        output cand1_vote, cand2_vote, cand3_vote, cand4_vote,
        output total_votes, valid_vote_casted, vote_rejected, busy
    );

endinterface

// File: rtl/vote_tally_counter.sv
// Per-candidate 8-bit saturating tally with synchronous clear.
module vote_tally_counter
    import evm_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              inc,
    input  logic              clr,
    output logic [VOTE_W-1:0] count,
    output logic              at_max
);

    assign at_max = (count == VOTE_MAX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + VOTE_W'(1);
        end
    end

endmodule

// File: rtl/vote_cast_controller.sv
// Qualifies candidate button presses and commits at most one vote per press.
//  state        | meaning
//  IDLE         | waiting for a single button press
//  DEBOUNCE     | latched button held, counting hold edges
//  WAIT_RELEASE | press consumed or rejected, waiting for all buttons low
//  LOCKOUT      | all released, counting quiet cycles before next press
module vote_cast_controller
    import evm_pkg::*;
#(
    parameter int HOLD_CYCLES    = 16,
    parameter int LOCKOUT_CYCLES = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    vote_cast_controller_if.slave   bus
);

    localparam int CNT_MAX = (HOLD_CYCLES > LOCKOUT_CYCLES) ? HOLD_CYCLES : LOCKOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [CAND_W-1:0]   idx;
    logic [TOTAL_W-1:0]  total;
    logic                valid_q;
    logic                reject_q;
    logic                busy_q;

    logic [NUM_CAND-1:0] btn;
    logic                single;
    logic                any_high;
    logic                others_high;
    logic                hold_done;
    logic                commit_ok;
    logic                commit_sat;
    logic                tally_clr;
    logic [NUM_CAND-1:0] tally_inc;
    logic [NUM_CAND-1:0] tally_at_max;
    logic [VOTE_W-1:0]   tally [NUM_CAND];

    assign btn = {bus.cand4_button_press, bus.cand3_button_press,
                  bus.cand2_button_press, bus.cand1_button_press};

    always_comb begin
        single      = $onehot(btn);
        any_high    = |btn;
        others_high = |(btn & ~idx_to_mask(idx));
        hold_done   = !bus.mode && (state == DEBOUNCE) && btn[idx]
                      && !others_high && (cnt == HOLD_LAST);
        // A full tally turns the commit into a rejection instead of a vote.
        commit_ok   = hold_done && !tally_at_max[idx];
        commit_sat  = hold_done && tally_at_max[idx];
        tally_inc   = commit_ok ? idx_to_mask(idx) : '0;
        tally_clr   = bus.mode && bus.clear_votes;
    end

    for (genvar g = 0; g < NUM_CAND; g++) begin : g_tally
        vote_tally_counter u_tally (
            .clock  (clock),
            .reset  (reset),
            .inc    (tally_inc[g]),
            .clr    (tally_clr),
            .count  (tally[g]),
            .at_max (tally_at_max[g])
        );
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            valid_q  <= 1'b0;
            reject_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            valid_q  <= 1'b0;
            reject_q <= 1'b0;
            if (bus.mode) begin
                state  <= IDLE;
                cnt    <= '0;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (single) begin
                            state  <= DEBOUNCE;
                            idx    <= onehot_to_idx(btn);
                            cnt    <= CNT_W'(1);
                            busy_q <= 1'b1;
                        end else if (any_high) begin
                            state    <= WAIT_RELEASE;
                            reject_q <= 1'b1;
                            busy_q   <= 1'b1;
                        end
                    end
                    DEBOUNCE: begin
                        if (!btn[idx]) begin
                            state  <= IDLE;
                            cnt    <= '0;
                            busy_q <= 1'b0;
                        end else if (others_high) begin
                            state    <= WAIT_RELEASE;
                            reject_q <= 1'b1;
                        end else if (cnt == HOLD_LAST) begin
                            state    <= WAIT_RELEASE;
                            valid_q  <= commit_ok;
                            reject_q <= commit_sat;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    WAIT_RELEASE: begin
                        if (!any_high) begin
                            state <= LOCKOUT;
                            cnt   <= '0;
                        end
                    end
                    LOCKOUT: begin
                        if (any_high) begin
                            state <= WAIT_RELEASE;
                        end else if (cnt == LOCK_LAST) begin
                            state  <= IDLE;
                            cnt    <= '0;
                            busy_q <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Never wraps: four saturating tallies sum to at most 1020.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            total <= '0;
        end else if (tally_clr) begin
            total <= '0;
        end else if (commit_ok) begin
            total <= total + TOTAL_W'(1);
        end
    end

    assign bus.cand1_vote        = tally[0];
    assign bus.cand2_vote        = tally[1];
    assign bus.cand3_vote        = tally[2];
    assign bus.cand4_vote        = tally[3];
    assign bus.total_votes       = total;
    assign bus.valid_vote_casted = valid_q;
    assign bus.vote_rejected     = reject_q;
    assign bus.busy              = busy_q;

endmodule

// File: tb/tb_vote_cast_controller.sv
// Directed bench for vote_cast_controller with HOLD_CYCLES=4, LOCKOUT_CYCLES=3.
module tb_vote_cast_controller;

    logic clock;
    logic reset;
    int   checks;
    int   failures;
    int   pulses;

    vote_cast_controller_if bus ();

    vote_cast_controller #(
        .HOLD_CYCLES    (4),
        .LOCKOUT_CYCLES (3)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_btn(input logic [3:0] b);
        bus.cand1_button_press = b[0];
        bus.cand2_button_press = b[1];
        bus.cand3_button_press = b[2];
        bus.cand4_button_press = b[3];
    endtask

    // From WAIT_RELEASE: one edge into LOCKOUT, two counting, third back to IDLE.
    task automatic release_to_idle(input string tag);
        set_btn(4'b0000);
        repeat (3) tick();
        check({tag, "_busy_lockout"}, 32'(bus.busy), 32'd1);
        tick();
        check({tag, "_busy_idle"}, 32'(bus.busy), 32'd0);
    endtask

    // Hold one button for exactly HOLD edges; expects a valid pulse after the 4th.
    task automatic press_commit(input string tag, input logic [3:0] b);
        set_btn(b);
        repeat (3) tick();
        check({tag, "_early_valid"}, 32'(bus.valid_vote_casted), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(bus.valid_vote_casted), 32'd1);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b0;
        bus.mode        = 1'b0;
        bus.clear_votes = 1'b0;
        set_btn(4'b0000);
        repeat (2) tick();
        check("rst_total", 32'(bus.total_votes), 32'd0);
        check("rst_cand1", 32'(bus.cand1_vote), 32'd0);
        check("rst_valid", 32'(bus.valid_vote_casted), 32'd0);
        check("rst_reject", 32'(bus.vote_rejected), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        reset = 1'b1;
        tick();

        // 1: cand2 held for 6 edges, pulse only after the 4th
        set_btn(4'b0010);
        pulses = 0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("t1_valid_edge%0d", k), 32'(bus.valid_vote_casted), (k == 4) ? 32'd1 : 32'd0);
            if (bus.valid_vote_casted) pulses++;
        end
        check("t1_pulses", 32'(pulses), 32'd1);
        check("t1_cand2", 32'(bus.cand2_vote), 32'd1);
        check("t1_total", 32'(bus.total_votes), 32'd1);
        release_to_idle("t1");

        // 2: cand1 held only 3 edges
        set_btn(4'b0001);
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) set_btn(4'b0000);
            tick();
            check($sformatf("t2_valid_edge%0d", k), 32'(bus.valid_vote_casted), 32'd0);
            check($sformatf("t2_reject_edge%0d", k), 32'(bus.vote_rejected), 32'd0);
        end
        check("t2_busy", 32'(bus.busy), 32'd0);
        check("t2_cand1", 32'(bus.cand1_vote), 32'd0);
        check("t2_total", 32'(bus.total_votes), 32'd1);

        // 3: cand1+cand3 together rejected, then cand3 alone counts
        set_btn(4'b0101);
        tick();
        check("t3_reject", 32'(bus.vote_rejected), 32'd1);
        check("t3_valid", 32'(bus.valid_vote_casted), 32'd0);
        tick();
        check("t3_reject_once", 32'(bus.vote_rejected), 32'd0);
        check("t3_cand1", 32'(bus.cand1_vote), 32'd0);
        check("t3_cand3_pre", 32'(bus.cand3_vote), 32'd0);
        release_to_idle("t3a");
        press_commit("t3", 4'b0100);
        check("t3_cand3", 32'(bus.cand3_vote), 32'd1);
        check("t3_total", 32'(bus.total_votes), 32'd2);
        release_to_idle("t3b");

        // 4: re-press during lockout goes back to WAIT_RELEASE with no vote
        press_commit("t4", 4'b1000);
        set_btn(4'b0000);
        tick();
        set_btn(4'b1000);
        pulses = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (bus.valid_vote_casted || bus.vote_rejected) pulses++;
        end
        check("t4_pulses", 32'(pulses), 32'd0);
        check("t4_busy", 32'(bus.busy), 32'd1);
        check("t4_cand4", 32'(bus.cand4_vote), 32'd1);
        check("t4_total", 32'(bus.total_votes), 32'd3);
        release_to_idle("t4");

        // clear_votes ignored in voting mode, honoured in result mode
        bus.clear_votes = 1'b1;
        tick();
        check("clr_ignored_total", 32'(bus.total_votes), 32'd3);
        bus.mode = 1'b1;
        tick();
        bus.mode        = 1'b0;
        bus.clear_votes = 1'b0;
        check("clr_total", 32'(bus.total_votes), 32'd0);
        check("clr_cand4", 32'(bus.cand4_vote), 32'd0);
        tick();

        // 5: saturate cand1 at 255, the next vote is rejected
        for (int v = 0; v < 255; v++) begin
            set_btn(4'b0001);
            repeat (4) tick();
            set_btn(4'b0000);
            repeat (4) tick();
        end
        check("t5_cand1_pre", 32'(bus.cand1_vote), 32'd255);
        check("t5_total_pre", 32'(bus.total_votes), 32'd255);
        set_btn(4'b0001);
        repeat (4) tick();
        check("t5_reject", 32'(bus.vote_rejected), 32'd1);
        check("t5_valid", 32'(bus.valid_vote_casted), 32'd0);
        check("t5_cand1", 32'(bus.cand1_vote), 32'd255);
        check("t5_total", 32'(bus.total_votes), 32'd255);
        tick();
        check("t5_reject_once", 32'(bus.vote_rejected), 32'd0);
        release_to_idle("t5");

        // 6: result mode discards a pending press, then clears
        set_btn(4'b0010);
        repeat (2) tick();
        check("t6_busy_debounce", 32'(bus.busy), 32'd1);
        bus.mode = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (bus.valid_vote_casted || bus.vote_rejected || bus.busy) pulses++;
        end
        check("t6_mode_quiet", 32'(pulses), 32'd0);
        check("t6_cand2", 32'(bus.cand2_vote), 32'd0);
        check("t6_total_kept", 32'(bus.total_votes), 32'd255);
        set_btn(4'b0000);
        bus.clear_votes = 1'b1;
        tick();
        bus.clear_votes = 1'b0;
        bus.mode        = 1'b0;
        check("t6_clr_cand1", 32'(bus.cand1_vote), 32'd0);
        check("t6_clr_total", 32'(bus.total_votes), 32'd0);
        tick();

        // async reset asserted mid-LOCKOUT
        press_commit("t6", 4'b0100);
        check("t6_cand3", 32'(bus.cand3_vote), 32'd1);
        set_btn(4'b0000);
        tick();
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_cand3", 32'(bus.cand3_vote), 32'd0);
        check("t6_rst_total", 32'(bus.total_votes), 32'd0);
        check("t6_rst_busy", 32'(bus.busy), 32'd0);
        check("t6_rst_valid", 32'(bus.valid_vote_casted), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        check("t6_post_busy", 32'(bus.busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
